// File: rtl/bcd_seg7_pkg.sv
// bcd_seg7_scan shared types and constants.
// Active-low 7-segment patterns {g,f,e,d,c,b,a} and scan FSM states.
package bcd_seg7_pkg;

  localparam int DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low 7-segment pattern.
// Non-decimal nibbles (A..F) show a dash.
module bcd_to_seg7
  import bcd_seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // pure lookup, dash for anything above 9
  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Double-buffered 3-digit common-anode 7-segment scanner.
// Optional BCD_SEG7_LZB_EN enables leading-zero blanking.
module bcd_seg7_scan
  import bcd_seg7_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] packed_bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [1:0] IDX_MAX = 2'(DIGITS - 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] disp_q, disp_d;
  logic [11:0] shadow_q, shadow_d;
  logic        pend_q, pend_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        tick;
  logic        frame_end;
  logic        accept;
  logic        blank;
  logic [3:0]  nib;
  logic [6:0]  dig_seg;

  assign in_ready  = !pend_q;
  assign accept    = in_valid && !pend_q;
  assign tick      = (state_q == SCAN) && (cnt_q == CNT_MAX);
  assign frame_end = tick && (idx_q == IDX_MAX);
  assign an        = an_q;
  assign seg       = seg_q;

  // pick the nibble of the digit being scanned
  always_comb begin
    nib = disp_q[3:0];
    case (idx_q)
      2'd1: nib = disp_q[7:4];
      2'd2: nib = disp_q[11:8];
      default: nib = disp_q[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (dig_seg)
  );

`ifdef BCD_SEG7_LZB_EN
  assign blank = ((idx_q == 2'd2) && (disp_q[11:8] == 4'd0)) ||
                 ((idx_q == 2'd1) && (disp_q[11:4] == 8'd0));
`else
  assign blank = 1'b0;
`endif

  // scan FSM, prescaler, buffers and registered digit drive
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    an_d     = 3'b111;
    seg_d    = SEG_BLANK;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          disp_d  = shadow_q;
          pend_d  = 1'b0;
          state_d = SCAN;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick)
          idx_d = (idx_q == IDX_MAX) ? 2'd0 : idx_q + 2'd1;
        if (frame_end && pend_q) begin
          disp_d = shadow_q;
          pend_d = 1'b0;
        end
        if (!blank) begin
          an_d  = ~(3'b001 << idx_q);
          seg_d = dig_seg;
        end
      end
    endcase
    if (accept) begin
      shadow_d = packed_bcd;
      pend_d   = 1'b1;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      disp_q   <= 12'd0;
      shadow_q <= 12'd0;
      pend_q   <= 1'b0;
      an_q     <= 3'b111;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

endmodule
